// File: rtl/vga_scanout_if.sv
// Drawer-facing coordinate/pixel bus plus the VGA DAC pins of vga_scanout.
// pattern_sel exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_scanout_if;
    logic [15:0] pixel_data;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        clk_vsync;
    logic        vga_hsync_n;
    logic        vga_vsync_n;
    logic [4:0]  vga_r;
    logic [5:0]  vga_g;
    logic [4:0]  vga_b;
    logic        vga_de;
`ifdef VGA_TEST_PATTERN_EN
    logic        pattern_sel;
`endif

    modport master (
`ifdef VGA_TEST_PATTERN_EN
        input  pattern_sel,
`endif
        input  pixel_data,
        output x, y, clk_vsync, vga_hsync_n, vga_vsync_n, vga_r, vga_g, vga_b, vga_de
    );

    modport slave (
`ifdef VGA_TEST_PATTERN_EN
        output pattern_sel,
`endif
        output pixel_data,
        input  x, y, clk_vsync, vga_hsync_n, vga_vsync_n, vga_r, vga_g, vga_b, vga_de
    );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA timing, 320x240 logical coordinates for the drawer and RGB565 pixel sink.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_scanout #(
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanout_if.master bus
);
    localparam logic [9:0] HVis       = 10'(H_VIS);
    localparam logic [9:0] HSyncStart = 10'(H_VIS + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] HLast      = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VVis       = 10'(V_VIS);
    localparam logic [9:0] VSyncStart = 10'(V_VIS + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] VLast      = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    // Stage 0: raster counters
    logic [9:0] hcnt_q, vcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (hcnt_q == HLast) begin
            hcnt_q <= '0;
            vcnt_q <= (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
        end else begin
            hcnt_q <= hcnt_q + 10'd1;
        end
    end

    // Stage 1: coordinates, frame strobe and raw de/sync
    logic [8:0] x_q, y_q;
    logic       vblank_q, de_q, hs_q, vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            vblank_q <= 1'b0;
            de_q     <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            x_q      <= (hcnt_q < HVis) ? hcnt_q[9:1] : '0;
            y_q      <= (vcnt_q < VVis) ? vcnt_q[9:1] : '0;
            vblank_q <= (vcnt_q >= VVis);
            de_q     <= (hcnt_q < HVis) && (vcnt_q < VVis);
            hs_q     <= !((hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd));
            vs_q     <= !((vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd));
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.clk_vsync = vblank_q;

    // Delay line matching the drawer's latency from x/y to pixel_data
    logic [PIPE_LAT-1:0] de_pipe, hs_pipe, vs_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_pipe <= '0;
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            de_pipe[0] <= de_q;
            hs_pipe[0] <= hs_q;
            vs_pipe[0] <= vs_q;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                de_pipe[i] <= de_pipe[i-1];
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    logic [15:0] src;

`ifdef VGA_TEST_PATTERN_EN
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        unique case (idx)
            3'd0: c = 16'hFFFF;
            3'd1: c = 16'hFFE0;
            3'd2: c = 16'h07FF;
            3'd3: c = 16'h07E0;
            3'd4: c = 16'hF81F;
            3'd5: c = 16'hF800;
            3'd6: c = 16'h001F;
            3'd7: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Bar index is taken from x and delayed so bars align exactly like pixel_data
    logic [2:0]               bar_idx;
    logic [PIPE_LAT-1:0][2:0] bar_pipe;

    always_comb begin
        bar_idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (x_q >= 9'(40 * i)) bar_idx = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_pipe <= '0;
        end else begin
            bar_pipe[0] <= bar_idx;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                bar_pipe[i] <= bar_pipe[i-1];
            end
        end
    end

    always_comb begin
        src = bus.pixel_data;
        if (bus.pattern_sel) src = bar_colour(bar_pipe[PIPE_LAT-1]);
    end
`else
    always_comb begin
        src = bus.pixel_data;
    end
`endif

    // Output stage: every pin changes on the same edge; blanking forces colour to 0
    logic [15:0] rgb_q;
    logic        de_out_q, hs_out_q, vs_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q    <= '0;
            de_out_q <= 1'b0;
            hs_out_q <= 1'b1;
            vs_out_q <= 1'b1;
        end else begin
            rgb_q    <= de_pipe[PIPE_LAT-1] ? src : '0;
            de_out_q <= de_pipe[PIPE_LAT-1];
            hs_out_q <= hs_pipe[PIPE_LAT-1];
            vs_out_q <= vs_pipe[PIPE_LAT-1];
        end
    end

    assign bus.vga_r       = rgb_q[15:11];
    assign bus.vga_g       = rgb_q[10:5];
    assign bus.vga_b       = rgb_q[4:0];
    assign bus.vga_de      = de_out_q;
    assign bus.vga_hsync_n = hs_out_q;
    assign bus.vga_vsync_n = vs_out_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: default horizontal timing, shortened frame (15 lines).
module tb_vga_scanout;
    localparam int unsigned PL    = 2;
    localparam int          FRAME = 800 * 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ffff_mode = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [8:0] xd1 = '0, xd2 = '0, yd1 = '0, yd2 = '0;

    vga_scanout_if bus ();

    vga_scanout #(
        .PIPE_LAT (PL),
        .V_VIS    (8),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drawer model: pixel derived from x/y delayed by PIPE_LAT clocks
    always @(posedge clk) begin
        xd1 <= bus.x;
        xd2 <= xd1;
        yd1 <= bus.y;
        yd2 <= yd1;
    end

    assign bus.pixel_data = ffff_mode ? 16'hFFFF : {xd2[4:0], yd2[5:0], xd2[4:0]};

`ifdef VGA_TEST_PATTERN_EN
    logic pat_sel = 1'b0;
    assign bus.pattern_sel = pat_sel;
`endif

    wire [15:0] rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    initial begin
        int   hfall1, hfall2, hrise1, vfall1, vfall2, cvrise1, cvrise2, cvfall, derise;
        int   hs_lo, vs_lo, de_hi, cv_hi, blank_bad, active_bad;
        logic [15:0] rgb_at_rise;
        logic prev_hs, prev_vs, prev_de, prev_cv;

        // Reset held for 10 cycles
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);
        check("rst_clk_vsync", bus.clk_vsync, 0);
        check("rst_hsync_n", bus.vga_hsync_n, 1);
        check("rst_vsync_n", bus.vga_vsync_n, 1);
        check("rst_de", bus.vga_de, 0);
        check("rst_rgb", rgb, 0);
        rst = 1'b0;

        // Two frames with the coordinate pixel pattern
        hfall1 = -1; hfall2 = -1; hrise1 = -1; vfall1 = -1; vfall2 = -1;
        cvrise1 = -1; cvfall = -1; derise = -1; rgb_at_rise = 16'hDEAD;
        hs_lo = 0; vs_lo = 0; de_hi = 0; cv_hi = 0; blank_bad = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_de = 1'b0; prev_cv = 1'b0;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            @(posedge clk);
            #1;
            if (!bus.vga_hsync_n) hs_lo++;
            if (!bus.vga_vsync_n) vs_lo++;
            if (bus.vga_de) de_hi++;
            if (bus.clk_vsync) cv_hi++;
            if (!bus.vga_de && rgb != 16'h0) blank_bad++;
            if (prev_hs && !bus.vga_hsync_n) begin
                if (hfall1 < 0) hfall1 = k;
                else if (hfall2 < 0) hfall2 = k;
            end
            if (!prev_hs && bus.vga_hsync_n && hrise1 < 0) hrise1 = k;
            if (prev_vs && !bus.vga_vsync_n) begin
                if (vfall1 < 0) vfall1 = k;
                else if (vfall2 < 0) vfall2 = k;
            end
            if (!prev_cv && bus.clk_vsync && cvrise1 < 0) cvrise1 = k;
            if (prev_cv && !bus.clk_vsync && cvfall < 0) cvfall = k;
            if (!prev_de && bus.vga_de && derise < 0) begin
                derise      = k;
                rgb_at_rise = rgb;
            end
            case (k)
                643:        check("pix_319_0", rgb, {5'd31, 6'd0, 5'd31});
                644:        check("de_off_hcnt640", bus.vga_de, 0);
                4014:       check("pix_5_2_line5", rgb, {5'd5, 6'd2, 5'd5});
                4814, 4815: check("pix_5_3_line6", rgb, {5'd5, 6'd3, 5'd5});
                4816:       check("pix_6_3_line6", rgb, {5'd6, 6'd3, 5'd6});
                5614, 5615: check("pix_5_3_line7", rgb, {5'd5, 6'd3, 5'd5});
                default: ;
            endcase
            prev_hs = bus.vga_hsync_n;
            prev_vs = bus.vga_vsync_n;
            prev_de = bus.vga_de;
            prev_cv = bus.clk_vsync;
        end
        check("first_de_rise", derise, PL + 2);
        check("rgb_at_de_rise", rgb_at_rise, 0);
        check("first_hsync_fall", hfall1, 656 + PL + 2);
        check("first_hsync_rise", hrise1, 656 + 96 + PL + 2);
        check("second_hsync_fall", hfall2, 800 + 656 + PL + 2);
        check("first_vsync_fall", vfall1, 10 * 800 + PL + 2);
        check("second_vsync_fall", vfall2, FRAME + 10 * 800 + PL + 2);
        check("clk_vsync_rise", cvrise1, 8 * 800 + 1);
        check("clk_vsync_fall", cvfall, FRAME + 1);
        check("hsync_low_total", hs_lo, 2 * 15 * 96);
        check("vsync_low_total", vs_lo, 2 * 1600);
        check("de_high_total", de_hi, 2 * 640 * 8);
        check("clk_vsync_high_total", cv_hi, 2 * 7 * 800);
        check("rgb_in_blank_coord", blank_bad, 0);

        // One frame with constant full-scale pixel data
        ffff_mode = 1'b1;
        blank_bad = 0; active_bad = 0; de_hi = 0;
        for (int k = 2 * FRAME + 1; k <= 3 * FRAME; k++) begin
            @(posedge clk);
            #1;
            if (!bus.vga_de && rgb != 16'h0) blank_bad++;
            if (bus.vga_de && rgb != 16'hFFFF) active_bad++;
            if (bus.vga_de) de_hi++;
        end
        check("rgb_in_blank_ffff", blank_bad, 0);
        check("rgb_active_ffff", active_bad, 0);
        check("de_high_frame3", de_hi, 640 * 8);

        // Advance into the vsync pulse (vcnt 11, hcnt 700) and reset for one cycle
        for (int k = 3 * FRAME + 1; k <= 3 * FRAME + 11 * 800 + 700; k++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_vsync_n", bus.vga_vsync_n, 0);
        check("pre_rst_hsync_n", bus.vga_hsync_n, 0);
        check("pre_rst_clk_vsync", bus.clk_vsync, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_x", bus.x, 0);
        check("midrst_y", bus.y, 0);
        check("midrst_clk_vsync", bus.clk_vsync, 0);
        check("midrst_hsync_n", bus.vga_hsync_n, 1);
        check("midrst_vsync_n", bus.vga_vsync_n, 1);
        check("midrst_de", bus.vga_de, 0);

`ifdef VGA_TEST_PATTERN_EN
        pat_sel = 1'b1;
`endif
        // Frame after the mid-frame reset
        hfall1 = -1; vfall1 = -1; cvrise1 = -1; cvrise2 = -1; derise = -1;
        hs_lo = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_de = 1'b0; prev_cv = 1'b0;
        for (int k = 1; k <= FRAME + 6500; k++) begin
            @(posedge clk);
            #1;
            if (k < 656 + PL + 2 && !bus.vga_hsync_n) hs_lo++;
            if (prev_hs && !bus.vga_hsync_n && hfall1 < 0) hfall1 = k;
            if (prev_vs && !bus.vga_vsync_n && vfall1 < 0) vfall1 = k;
            if (!prev_de && bus.vga_de && derise < 0) derise = k;
            if (!prev_cv && bus.clk_vsync) begin
                if (cvrise1 < 0) cvrise1 = k;
                else if (cvrise2 < 0) cvrise2 = k;
            end
`ifdef VGA_TEST_PATTERN_EN
            if (k == 800 + 90 + PL + 2) check("pattern_x45_yellow", rgb, 16'hFFE0);
            if (k == 800 + 600 + PL + 2) check("pattern_x300_black", rgb, 16'h0000);
`else
            if (k == 800 + 90 + PL + 2) check("pixel_x45_ffff", rgb, 16'hFFFF);
            if (k == 800 + 600 + PL + 2) check("pixel_x300_ffff", rgb, 16'hFFFF);
`endif
            prev_hs = bus.vga_hsync_n;
            prev_vs = bus.vga_vsync_n;
            prev_de = bus.vga_de;
            prev_cv = bus.clk_vsync;
        end
        check("midrst_no_partial_hsync", hs_lo, 0);
        check("midrst_first_hsync_fall", hfall1, 656 + PL + 2);
        check("midrst_first_de_rise", derise, PL + 2);
        check("midrst_vsync_fall", vfall1, 10 * 800 + PL + 2);
        check("midrst_clk_vsync_rise1", cvrise1, 8 * 800 + 1);
        check("midrst_clk_vsync_rise2", cvrise2, FRAME + 8 * 800 + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
